// File: rtl/pulse_width_encoder_pkg.sv
// ---------------------------------------------------------------------------
// pulse_width_encoder_pkg
// Shared types and constants for the pulse width encoder slice.
//   LATENCY  : cycles from a DIN_VALID sample to its DOUT_VALID output
//   state_t  : frame sequencer states
//   idx_t    : duty-table index (intensity * modulation)
//   pw_t     : pulse width / phase byte
//   tr_idx_t : transducer index within a frame
// ---------------------------------------------------------------------------
package pulse_width_encoder_pkg;

  localparam int LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic [15:0] idx_t;
  typedef logic [7:0]  pw_t;
  typedef logic [7:0]  tr_idx_t;

endpackage

// File: rtl/pwe_delay_line.sv
// ---------------------------------------------------------------------------
// pwe_delay_line
// Fixed-length shift register that keeps sample side-band data (valid,
// phase, frame-start flag) in step with the duty-table read latency.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset (clears every stage)
//   din        : word entering stage 0
//   dout       : word leaving the last stage
//   lsb_taps   : bit 0 of every stage; the caller packs its valid bit there
//                so it can tell which stages still hold a live sample
// ---------------------------------------------------------------------------
module pwe_delay_line #(
  parameter int WIDTH  = 1,
  parameter int LENGTH = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic [LENGTH-1:0] lsb_taps
);

  logic [WIDTH-1:0] stage_r [LENGTH];

  // Shift every stage one place per clock; reset empties the line at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < LENGTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < LENGTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // Expose the per-stage valid bits.
  always_comb begin
    lsb_taps = '0;
    for (int i = 0; i < LENGTH; i++) begin
      lsb_taps[i] = stage_r[i][0];
    end
  end

  assign dout = stage_r[LENGTH-1];

endmodule

// File: rtl/pulse_width_encoder.sv
// ---------------------------------------------------------------------------
// pulse_width_encoder
// Turns per-transducer intensity/modulation into a duty-table index, reads
// the pulse width back from the table and emits it together with the
// transducer's phase and index, LATENCY cycles after the sample arrived.
//
// Optional build macro: PULSE_WIDTH_ENCODER_FRAME_CHECK_EN
//   defined   : a gap inside a frame is a short frame -> ERR pulse, the
//               input index restarts at 0
//   undefined : ERR is 0, gaps are tolerated and the index resumes
//
// Ports:
//   CLK, RST_N        : clock, asynchronous active-low reset
//   DIN_VALID         : one transducer sample per high cycle
//   INTENSITY_IN      : transducer intensity
//   PHASE_IN          : transducer phase
//   MOD_IN            : frame modulation value
//   DUTY_TABLE_IDX    : table index to the duty-table port (IDX)
//   DUTY_TABLE_VALUE  : table data from the duty-table port (VALUE)
//   DOUT_VALID        : output sample valid
//   PULSE_WIDTH_OUT   : table value for the transducer
//   PHASE_OUT         : phase aligned with PULSE_WIDTH_OUT
//   DOUT_IDX          : transducer index of the output sample
//   BUSY              : a frame is open or a sample is in flight
//   ERR               : one-cycle short-frame pulse
// ---------------------------------------------------------------------------
module pulse_width_encoder
  import pulse_width_encoder_pkg::*;
#(
  parameter int DEPTH       = 249,
  parameter int MEM_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DIN_VALID,
  input  logic [7:0]  INTENSITY_IN,
  input  logic [7:0]  PHASE_IN,
  input  logic [7:0]  MOD_IN,
  output logic [15:0] DUTY_TABLE_IDX,
  input  logic [7:0]  DUTY_TABLE_VALUE,
  output logic        DOUT_VALID,
  output logic [7:0]  PULSE_WIDTH_OUT,
  output logic [7:0]  PHASE_OUT,
  output logic [7:0]  DOUT_IDX,
  output logic        BUSY,
  output logic        ERR
);

  // Side-band word through the delay line: {phase, frame_start, valid}.
  localparam int LINE_W = 10;
  // Marks the last delay stage; its sample leaves the line next clock.
  localparam logic [MEM_LATENCY-1:0] LAST_MASK =
    MEM_LATENCY'(1'b1) << (MEM_LATENCY - 1);

  state_t                 state_r;
  state_t                 state_next_s;
  tr_idx_t                in_cnt_r;
  tr_idx_t                out_cnt_r;
  tr_idx_t                out_idx_s;
  tr_idx_t                out_cnt_next_s;
  idx_t                   idx_r;
  pw_t                    phase0_r;
  logic                   v0_r;
  logic                   sof0_r;
  logic                   last_in_s;
  logic                   short_frame_s;
  logic                   pending_s;
  logic                   busy_s;
  logic [LINE_W-1:0]      line_in_s;
  logic [LINE_W-1:0]      line_out_s;
  logic [MEM_LATENCY-1:0] line_v_s;
  logic                   v_d_s;
  logic                   sof_d_s;
  pw_t                    phase_d_s;

  assign last_in_s = (in_cnt_r == tr_idx_t'(DEPTH - 1));

`ifdef PULSE_WIDTH_ENCODER_FRAME_CHECK_EN
  // A gap while the frame is part-way through is flagged in the same cycle.
  assign short_frame_s = !DIN_VALID && (in_cnt_r != 8'd0);
`else
  assign short_frame_s = 1'b0;
`endif

  // Input transducer counter: wraps seamlessly, restarts on a short frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_cnt_r <= 8'd0;
    end else if (DIN_VALID) begin
      in_cnt_r <= last_in_s ? 8'd0 : in_cnt_r + 8'd1;
    end else if (short_frame_s) begin
      in_cnt_r <= 8'd0;
    end else begin
      in_cnt_r <= in_cnt_r;
    end
  end

  // Index stage: form the table index; IDX holds while no sample arrives.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_r    <= 16'd0;
      phase0_r <= 8'd0;
      sof0_r   <= 1'b0;
      v0_r     <= 1'b0;
    end else begin
      v0_r <= DIN_VALID;
      if (DIN_VALID) begin
        idx_r    <= 16'(INTENSITY_IN) * 16'(MOD_IN);
        phase0_r <= PHASE_IN;
        sof0_r   <= (in_cnt_r == 8'd0);
      end else begin
        idx_r    <= idx_r;
        phase0_r <= phase0_r;
        sof0_r   <= sof0_r;
      end
    end
  end

  assign DUTY_TABLE_IDX = idx_r;
  assign line_in_s      = {phase0_r, sof0_r, v0_r};

  pwe_delay_line #(
    .WIDTH  (LINE_W),
    .LENGTH (MEM_LATENCY)
  ) u_align (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .din      (line_in_s),
    .dout     (line_out_s),
    .lsb_taps (line_v_s)
  );

  assign phase_d_s = line_out_s[9:2];
  assign sof_d_s   = line_out_s[1];
  assign v_d_s     = line_out_s[0];

  // Output index: restarts at each frame start so gaps never skew it.
  always_comb begin
    out_idx_s      = 8'd0;
    out_cnt_next_s = 8'd0;
    if (sof_d_s) begin
      out_idx_s = 8'd0;
    end else begin
      out_idx_s = out_cnt_r;
    end
    if (out_idx_s == tr_idx_t'(DEPTH - 1)) begin
      out_cnt_next_s = 8'd0;
    end else begin
      out_cnt_next_s = out_idx_s + 8'd1;
    end
  end

  // Output register: capture the table value when its sample arrives.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DOUT_VALID      <= 1'b0;
      PULSE_WIDTH_OUT <= 8'd0;
      PHASE_OUT       <= 8'd0;
      DOUT_IDX        <= 8'd0;
      out_cnt_r       <= 8'd0;
    end else if (v_d_s) begin
      DOUT_VALID      <= 1'b1;
      PULSE_WIDTH_OUT <= DUTY_TABLE_VALUE;
      PHASE_OUT       <= phase_d_s;
      DOUT_IDX        <= out_idx_s;
      out_cnt_r       <= out_cnt_next_s;
    end else begin
      DOUT_VALID      <= 1'b0;
      PULSE_WIDTH_OUT <= PULSE_WIDTH_OUT;
      PHASE_OUT       <= PHASE_OUT;
      DOUT_IDX        <= DOUT_IDX;
      out_cnt_r       <= out_cnt_r;
    end
  end

  // Samples that will still sit before the output register next cycle.
  assign pending_s = v0_r | (|(line_v_s & ~LAST_MASK));

  // Frame sequencer state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame sequencer next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (DIN_VALID) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (DIN_VALID && last_in_s) begin
          state_next_s = DRAIN;
        end else if (short_frame_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        if (DIN_VALID) begin
          state_next_s = RUN;
        end else if (!pending_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Frame sequencer outputs: busy while a frame is open or data in flight.
  always_comb begin
    busy_s = 1'b0;
    if (state_r != IDLE) begin
      busy_s = 1'b1;
    end else begin
      busy_s = v0_r | (|line_v_s);
    end
  end

  assign BUSY = busy_s;
  assign ERR  = short_frame_s;

endmodule

// File: tb/tb_pulse_width_encoder.sv
// ---------------------------------------------------------------------------
// tb_pulse_width_encoder
// Directed sequence with random data. The reference model keeps one record
// per applied cycle; the output seen in a cycle must match the record from
// LATENCY cycles earlier. Includes a 2-cycle duty-table memory model.
// ---------------------------------------------------------------------------
module tb_pulse_width_encoder;
  import pulse_width_encoder_pkg::*;

  localparam int DEPTH = 249;

  typedef struct {
    logic       v;
    logic [7:0] pw;
    logic [7:0] ph;
    logic [7:0] idx;
  } rec_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        DIN_VALID = 1'b0;
  logic [7:0]  INTENSITY_IN = 8'd0;
  logic [7:0]  PHASE_IN = 8'd0;
  logic [7:0]  MOD_IN = 8'd0;
  logic [15:0] DUTY_TABLE_IDX;
  logic [7:0]  DUTY_TABLE_VALUE = 8'd0;
  logic        DOUT_VALID;
  logic [7:0]  PULSE_WIDTH_OUT;
  logic [7:0]  PHASE_OUT;
  logic [7:0]  DOUT_IDX;
  logic        BUSY;
  logic        ERR;

  logic [7:0]  mem [0:65535];
  logic [7:0]  mem_q1 = 8'd0;

  int          n_vec = 0;
  int          n_miscmp = 0;
  rec_t        hist[$];
  int          frame_idx = 0;
  logic [15:0] last_idx = 16'd0;

  pulse_width_encoder dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .DIN_VALID        (DIN_VALID),
    .INTENSITY_IN     (INTENSITY_IN),
    .PHASE_IN         (PHASE_IN),
    .MOD_IN           (MOD_IN),
    .DUTY_TABLE_IDX   (DUTY_TABLE_IDX),
    .DUTY_TABLE_VALUE (DUTY_TABLE_VALUE),
    .DOUT_VALID       (DOUT_VALID),
    .PULSE_WIDTH_OUT  (PULSE_WIDTH_OUT),
    .PHASE_OUT        (PHASE_OUT),
    .DOUT_IDX         (DOUT_IDX),
    .BUSY             (BUSY),
    .ERR              (ERR)
  );

  always #24 CLK = ~CLK;

  // Duty-table port: VALUE is valid two clocks after IDX changes.
  always @(posedge CLK) begin
    mem_q1           <= mem[DUTY_TABLE_IDX];
    DUTY_TABLE_VALUE <= mem_q1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic init_asin_table();
    for (int i = 0; i < 65536; i++) begin
      real x;
      x = (i > 65025) ? 1.0 : real'(i) / 65025.0;
      mem[i] = 8'($rtoi($asin(x) * 2.0 / 3.141592653589793 * 255.0 + 0.5));
    end
  endtask

  task automatic write_duty_table();
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
  endtask

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < LATENCY; i++) hist.push_back('{1'b0, 8'd0, 8'd0, 8'd0});
    frame_idx = 0;
    last_idx  = 16'd0;
  endtask

  // One clock: drive a sample (or a gap), then check the DUT mid-cycle.
  task automatic cycle(input logic v, input logic [7:0] inten, input logic [7:0] ph,
                       input logic [7:0] md);
    rec_t        r;
    rec_t        o;
    logic        exp_err;
    logic        exp_busy;
    logic [15:0] exp_idx;
    @(posedge CLK); #1;
    DIN_VALID = v; INTENSITY_IN = inten; PHASE_IN = ph; MOD_IN = md;
    exp_busy = (frame_idx != 0) || hist[0].v || hist[1].v || hist[2].v;
    exp_idx  = last_idx;
    exp_err  = 1'b0;
    r = '{1'b0, 8'd0, 8'd0, 8'd0};
    if (v) begin
      r.v  = 1'b1;
      r.pw = mem[int'(inten) * int'(md)];
      r.ph = ph;
      r.idx = 8'(frame_idx);
      frame_idx = (frame_idx + 1) % DEPTH;
      last_idx  = 16'(int'(inten) * int'(md));
    end
`ifdef PULSE_WIDTH_ENCODER_FRAME_CHECK_EN
    else if (frame_idx != 0) begin
      exp_err   = 1'b1;
      frame_idx = 0;
    end
`endif
    o = hist[LATENCY-1];
    @(negedge CLK);
    check("dout_valid", 16'(DOUT_VALID), 16'(o.v));
    if (o.v) begin
      check("pulse_width", 16'(PULSE_WIDTH_OUT), 16'(o.pw));
      check("phase_out", 16'(PHASE_OUT), 16'(o.ph));
      check("dout_idx", 16'(DOUT_IDX), 16'(o.idx));
    end
    check("busy", 16'(BUSY), 16'(exp_busy));
    check("err", 16'(ERR), 16'(exp_err));
    check("table_idx", DUTY_TABLE_IDX, exp_idx);
    hist.push_front(r);
    void'(hist.pop_back());
  endtask

  // Assert reset mid-cycle, check everything is cleared, then release.
  task automatic apply_reset();
    @(posedge CLK); #1;
    RST_N = 1'b0;
    DIN_VALID = 1'b0;
    @(negedge CLK);
    check("rst_dout_valid", 16'(DOUT_VALID), 16'd0);
    check("rst_pulse_width", 16'(PULSE_WIDTH_OUT), 16'd0);
    check("rst_phase_out", 16'(PHASE_OUT), 16'd0);
    check("rst_dout_idx", 16'(DOUT_IDX), 16'd0);
    check("rst_busy", 16'(BUSY), 16'd0);
    check("rst_err", 16'(ERR), 16'd0);
    check("rst_table_idx", DUTY_TABLE_IDX, 16'd0);
    model_clear();
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  initial begin
    init_asin_table();
    model_clear();
    apply_reset();

    // Full-scale frame, then idle so BUSY can be seen falling.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'hFF, 8'(i), 8'hFF);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'd0, 8'd0, 8'd0);

    // Three back-to-back random frames against a random table.
    write_duty_table();
    for (int i = 0; i < 3 * DEPTH; i++)
      cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'd0, 8'd0, 8'd0);

    // Zero intensity or zero modulation against the asin table.
    init_asin_table();
    for (int i = 0; i < DEPTH; i++) begin
      if ($urandom_range(1, 0) == 1)
        cycle(1'b1, 8'd0, 8'($urandom), 8'($urandom));
      else
        cycle(1'b1, 8'($urandom), 8'($urandom), 8'd0);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'd0, 8'd0, 8'd0);

    // Frame interrupted after 100 samples, then more samples.
    write_duty_table();
    for (int i = 0; i < 100; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'd0, 8'd0, 8'd0);

    // Reset two cycles into a frame; nothing may come out afterwards.
    apply_reset();
    for (int i = 0; i < 2; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    apply_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'd0, 8'd0, 8'd0);

    // Fresh frame after reset, with random seamless continuation.
    for (int i = 0; i < DEPTH + 10; i++)
      cycle(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'd0, 8'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/pulse_width_encoder.md
Name: pulse_width_encoder

Overview:
- Stage directly upstream of the duty-table memory port (duty_table_bus_if, out_port side).
- Consumes per-transducer intensity, phase and modulation streamed once per frame. Forms the 16-bit table index intensity*modulation and drives IDX. Captures the 8-bit VALUE (pulse width) and emits it phase-aligned with the transducer's phase.
- Output feeds the PWM generator stage.

Parameters:
- DEPTH, 249, transducers per frame; counter range 0..DEPTH-1.
- MEM_LATENCY, 2, cycles from IDX change to valid VALUE on duty_table_bus.

Ports:
- CLK  input  1  system clock (20.48 MHz domain).
- RST_N  input  1  asynchronous active-low reset.
- DIN_VALID  input  1  high for each transducer sample; a frame is DEPTH consecutive valid cycles.
- INTENSITY_IN  input  8  transducer intensity.
- PHASE_IN  input  8  transducer phase.
- MOD_IN  input  8  modulation value for the current frame.
- DUTY_TABLE_BUS  modport  -  out_port of duty_table_bus_if; drives IDX[15:0], reads VALUE[7:0].
- DOUT_VALID  output  1  pulse width/phase valid.
- PULSE_WIDTH_OUT  output  8  table VALUE for the transducer.
- PHASE_OUT  output  8  PHASE_IN delayed to align.
- DOUT_IDX  output  8  transducer index 0..DEPTH-1 of current output.
- BUSY  output  1  high while any sample is in flight.
- ERR  output  1  one-cycle pulse on frame-length violation.

Behaviour:
- Reset: all outputs 0, IDX 0, counters 0, state IDLE. Assertion mid-frame discards in-flight samples immediately. No output pulse after release until new DIN_VALID.
- Pipeline, fixed latency 4 cycles, sample at cycle t:
  - t+1: IDX registered = INTENSITY_IN*MOD_IN, unsigned 8x8 to 16 bit, max 65025, no truncation.
  - t+1+MEM_LATENCY: VALUE valid.
  - t+4: PULSE_WIDTH_OUT registered with DOUT_VALID=1. PHASE_OUT and DOUT_IDX carry the same sample's values.
- One sample per cycle at full throughput; no backpressure; no stall.
- IDX holds its last value when DIN_VALID is low.
- Input counter: increments on each DIN_VALID; wraps DEPTH-1 to 0. DIN_VALID held beyond DEPTH starts the next frame seamlessly with no bubble.
- State machine:
  - IDLE: DIN_VALID goes to RUN.
  - RUN: counter==DEPTH-1 with DIN_VALID goes to DRAIN. DIN_VALID low with counter!=0 is a short frame (see Optional Feature).
  - DRAIN: outputs the last 4 samples, then returns to IDLE. DIN_VALID in DRAIN goes straight to RUN, with the pipeline continuing.
- BUSY = (state!=IDLE) OR any pipeline valid bit set.
- DOUT_IDX is a separate output counter, reset at each frame start, so it matches the input index regardless of gaps.

Optional Feature:
- Macro: PULSE_WIDTH_ENCODER_FRAME_CHECK_EN.
- Defined: DIN_VALID low while counter is in 1..DEPTH-1 is a short frame:
  - ERR pulses 1 cycle, coincident with the first invalid cycle.
  - Input counter resets to 0.
  - Samples already issued still emerge normally.
  - Next DIN_VALID starts a new frame at index 0.
- Undefined: ERR tied 0. Gaps are tolerated and the counter resumes from its held value.

Decomposition:
- Package pulse_width_encoder_pkg:
  - LATENCY=4 localparam.
  - state enum {IDLE, RUN, DRAIN}.
  - typedefs idx_t (16 bit), pw_t (8 bit), tr_idx_t (8 bit).
- Sub-module pwe_delay_line: parameterised width and length shift register with async active-low reset. Aligns valid, phase and index with the memory latency.

Test Plan:
- Full frame, INTENSITY_IN=0xFF, MOD_IN=0xFF, all 249 samples -> IDX=65025; 249 DOUT_VALID cycles starting exactly 4 cycles after the first DIN_VALID; DOUT_IDX 0..248; PULSE_WIDTH_OUT equals table entry 65025.
- Random intensity/mod/phase, table loaded via write_duty_table with random bytes -> each PULSE_WIDTH_OUT equals buffer[intensity*mod] and PHASE_OUT equals the input phase, for 3 back-to-back frames with no gaps.
- INTENSITY_IN=0 or MOD_IN=0 -> IDX=0 and output equals table[0] (asin-initialised table gives 0).
- DIN_VALID dropped after 100 samples (macro defined) -> ERR pulse at cycle 100; 100 outputs; next frame DOUT_IDX starts at 0. Macro undefined -> ERR stays 0 and index resumes at 100.
- RST_N asserted 2 cycles after frame start -> all outputs 0 next edge and BUSY=0; no DOUT_VALID until a new frame arrives.
- Frame followed by idle -> BUSY falls exactly 4 cycles after the last DIN_VALID; state returns to IDLE.
